// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared encodings for the memory bus arbiter (state, owner tags).
// Revision : 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_DATA_WIDTH = 8;

    localparam logic [1:0] ST_CPU_PRIO = 2'd0;
    localparam logic [1:0] ST_DBG_PRIO = 2'd1;
    localparam logic [1:0] ST_DBG_LOCK = 2'd2;

    localparam logic TAG_CPU = 1'b0;
    localparam logic TAG_DBG = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mem_arb_rd_tracker.sv
// ============================================================================
// Module   : mem_arb_rd_tracker
// Brief    : Read-owner tag pipeline and per-requester rdata/rvalid registers.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_arb_rd_tracker
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  rd_push,
    input  logic                  rd_tag,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  dbg_rvalid,
    output logic [DATA_WIDTH-1:0] dbg_rdata
);

    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [READ_LATENCY-1:0] tag_q, tag_d;
    logic                    cpu_rvalid_q, cpu_rvalid_d;
    logic                    dbg_rvalid_q, dbg_rvalid_d;
    logic [DATA_WIDTH-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_WIDTH-1:0]   dbg_rdata_q, dbg_rdata_d;

    // The last pipeline stage lines up with the cycle mem_rdata is valid.
    always_comb begin
        vld_d        = vld_q << 1;
        vld_d[0]     = rd_push;
        tag_d        = tag_q << 1;
        tag_d[0]     = rd_tag;
        cpu_rvalid_d = vld_q[READ_LATENCY-1] && (tag_q[READ_LATENCY-1] == TAG_CPU);
        dbg_rvalid_d = vld_q[READ_LATENCY-1] && (tag_q[READ_LATENCY-1] == TAG_DBG);
        cpu_rdata_d  = cpu_rvalid_d ? mem_rdata : cpu_rdata_q;
        dbg_rdata_d  = dbg_rvalid_d ? mem_rdata : dbg_rdata_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_q        <= '0;
            tag_q        <= '0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            vld_q        <= vld_d;
            tag_q        <= tag_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    assign cpu_rvalid = cpu_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign dbg_rvalid = dbg_rvalid_q;
    assign dbg_rdata  = dbg_rdata_q;

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module   : mem_bus_arbiter
// Brief    : CPU/debug arbiter for a single-port memory with dbg starvation
//            limit. Define MEM_ARB_LOCK_EN to add the dbg_lock bus lock.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int READ_LATENCY = 1,
    parameter int MAX_CPU_RUN  = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
`ifdef MEM_ARB_LOCK_EN
    input  logic                  dbg_lock,
`endif
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int                CNT_W      = $clog2(MAX_CPU_RUN + 1);
    localparam logic [CNT_W-1:0]  c_run_last = CNT_W'(MAX_CPU_RUN - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lock_w;

`ifdef MEM_ARB_LOCK_EN
    assign lock_w = dbg_lock;
`else
    assign lock_w = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_CPU_PRIO;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_DBG_PRIO: begin
                state_d = ST_CPU_PRIO;
                cnt_d   = '0;
            end
`ifdef MEM_ARB_LOCK_EN
            ST_DBG_LOCK: begin
                cnt_d = '0;
                if (!lock_w) state_d = ST_CPU_PRIO;
            end
`endif
            default: begin
                state_d = ST_CPU_PRIO;
                if (dbg_gnt || !dbg_req) begin
                    cnt_d = '0;
                end else if (cpu_gnt) begin
                    if (cnt_q == c_run_last) begin
                        state_d = ST_DBG_PRIO;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase
        // A locked dbg grant from either priority state takes the bus.
        if (dbg_gnt && lock_w && (state_q != ST_DBG_LOCK)) begin
            state_d = ST_DBG_LOCK;
            cnt_d   = '0;
        end
    end

    // Grants are held low while resetn is asserted, even with requests present.
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (resetn) begin
            case (state_q)
                ST_DBG_PRIO: begin
                    dbg_gnt = dbg_req;
                    cpu_gnt = cpu_req && !dbg_req;
                end
`ifdef MEM_ARB_LOCK_EN
                ST_DBG_LOCK: begin
                    dbg_gnt = dbg_req;
                end
`endif
                default: begin
                    cpu_gnt = cpu_req;
                    dbg_gnt = dbg_req && !cpu_req;
                end
            endcase
        end
    end

    always_comb begin
        mem_en    = cpu_gnt || dbg_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    mem_arb_rd_tracker #(
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_rd_tracker (
        .clk        (clk),
        .resetn     (resetn),
        .rd_push    (mem_en && !mem_we),
        .rd_tag     (dbg_gnt ? TAG_DBG : TAG_CPU),
        .mem_rdata  (mem_rdata),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata)
    );

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Brief    : Scoreboard bench for mem_bus_arbiter with a behavioural 1-cycle RAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;

    localparam int RL = 1;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [15:0] dbg_addr = '0;
    logic [7:0]  dbg_wdata = '0;
`ifdef MEM_ARB_LOCK_EN
    logic        dbg_lock = 1'b0;
`endif
    logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic [7:0]  cpu_rdata, dbg_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;

    logic [7:0]  ram [0:65535];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        bit         tag;
        logic [7:0] data;
        int         due;
    } exp_t;
    exp_t sb[$];

    mem_bus_arbiter #(
        .ADDR_WIDTH(16), .DATA_WIDTH(8), .READ_LATENCY(RL), .MAX_CPU_RUN(4)
    ) dut (
        .clk(clk), .resetn(resetn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
`ifdef MEM_ARB_LOCK_EN
        .dbg_lock(dbg_lock),
`endif
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rvalid pops the oldest expected read and compares.
    always @(negedge clk) begin
        if (cpu_rvalid || dbg_rvalid) begin
            if (cpu_rvalid && dbg_rvalid) begin
                check("both_rvalid", {cpu_rvalid, dbg_rvalid}, 2'b00);
            end else if (sb.size() == 0) begin
                check("unexpected_rvalid", {cpu_rvalid, dbg_rvalid}, 2'b00);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rd_owner", {31'd0, dbg_rvalid}, {31'd0, e.tag});
                check("rd_data", {24'd0, (dbg_rvalid ? dbg_rdata : cpu_rdata)}, {24'd0, e.data});
                check("rd_cycle", cyc, e.due);
            end
        end
    end

    task automatic access(input bit is_dbg, input bit we, input logic [15:0] addr,
                          input logic [7:0] wdata, input logic [7:0] exp_rd);
        bit got;
        int n;
        got = 1'b0;
        n   = 0;
        if (is_dbg) begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        while (!got && n < 20) begin
            @(negedge clk);
            got = is_dbg ? dbg_gnt : cpu_gnt;
            n++;
        end
        check(is_dbg ? "dbg_gnt_wait" : "cpu_gnt_wait", {31'd0, got}, 32'd1);
        if (got && !we) sb.push_back('{tag: is_dbg, data: exp_rd, due: cyc + RL + 1});
        @(posedge clk); #1;
        cpu_req = 1'b0;
        dbg_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1);
    end

    initial begin
        string pat;
        pat = "CCCCDCCCCD";
        ram[16'hFFFC] = 8'h00;
        ram[16'hFFFD] = 8'h80;

        // Reset held with a pending cpu read request.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hFFFC;
        @(negedge clk);
        @(negedge clk);
        check("rst_gnt", {cpu_gnt, dbg_gnt}, 2'b00);
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_rvalid", {cpu_rvalid, dbg_rvalid}, 2'b00);
        check("rst_rdata", {cpu_rdata, dbg_rdata}, 16'h0000);
        check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);

        // Release: the held cpu read is granted immediately, then FFFD back-to-back.
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        check("rel_cpu_gnt", {cpu_gnt, dbg_gnt}, 2'b10);
        sb.push_back('{tag: 1'b0, data: 8'h00, due: cyc + RL + 1});
        @(posedge clk); #1;
        access(1'b0, 1'b0, 16'hFFFD, 8'h00, 8'h80);
        idle(4);

        // Both requesting: dbg gets one slot after every four cpu grants.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0300; cpu_wdata = 8'h5C;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0301; dbg_wdata = 8'h3D;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("starve_gnt", {cpu_gnt, dbg_gnt}, (pat[i] == "C") ? 2'b10 : 2'b01);
            check("starve_addr", {16'd0, mem_addr}, (pat[i] == "C") ? 32'h0300 : 32'h0301);
            @(posedge clk); #1;
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        idle(1);

        // dbg loads, cpu and dbg read back in consecutive cycles.
        access(1'b1, 1'b1, 16'h0200, 8'hA9, 8'h00);
        access(1'b0, 1'b0, 16'h0200, 8'h00, 8'hA9);
        access(1'b1, 1'b0, 16'h0300, 8'h00, 8'h5C);
        access(1'b0, 1'b0, 16'h0301, 8'h00, 8'h3D);
        access(1'b1, 1'b0, 16'h0301, 8'h00, 8'h3D);
        idle(4);
        check("drain_before_rst", sb.size(), 32'd0);

        // Reset one cycle after a granted read: the read must vanish.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0200;
        @(negedge clk);
        check("mid_cpu_gnt", {cpu_gnt, dbg_gnt}, 2'b10);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        resetn  = 1'b0;
        idle(2);
        resetn = 1'b1;
        @(negedge clk);
        check("mid_rdata_cleared", {cpu_rdata, dbg_rdata}, 16'h0000);
        idle(4);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0400; cpu_wdata = 8'h11;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0401; dbg_wdata = 8'h22;
        @(negedge clk);
        check("post_rst_cpu_prio", {cpu_gnt, dbg_gnt}, 2'b10);
        @(posedge clk); #1;
        cpu_req = 1'b0; dbg_req = 1'b0;
        idle(2);

`ifdef MEM_ARB_LOCK_EN
        // Lock: dbg takes the bus, cpu is stalled until one cycle after the drop.
        dbg_lock = 1'b1; dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0500; dbg_wdata = 8'h01;
        @(negedge clk);
        check("lock_entry_gnt", {cpu_gnt, dbg_gnt}, 2'b01);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0600; cpu_wdata = 8'h77;
        for (int i = 0; i < 10; i++) begin
            dbg_addr = 16'h0501 + 16'(i);
            @(negedge clk);
            check("lock_gnt", {cpu_gnt, dbg_gnt}, 2'b01);
            @(posedge clk); #1;
        end
        dbg_lock = 1'b0; dbg_req = 1'b0;
        @(negedge clk);
        check("lock_exit_stall", {31'd0, cpu_gnt}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("lock_release_gnt", {31'd0, cpu_gnt}, 32'd1);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        idle(2);
`endif

        idle(4);
        check("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single-port 64KB memory_block between two requesters:
  - the 6502 core (cpu port);
  - a debug/loader master (dbg port) that preloads programs and inspects memory.
- Issues at most one memory access per clk cycle.
- Tags in-flight reads so the returned data is steered to the requester that issued them.
- Fixed CPU priority, with a starvation limit for dbg.

Parameters:
- ADDR_WIDTH, 16, memory address width.
- DATA_WIDTH, 8, memory data width.
- READ_LATENCY, 1, cycles from mem_en (read) to valid mem_rdata; legal range 1..4.
- MAX_CPU_RUN, 4, consecutive CPU grants allowed while dbg_req is pending before dbg is forced a grant.

Ports:
- clk  in  1  system clock; memory is clocked from the same clock.
- resetn  in  1  asynchronous, active-low reset.
- cpu_req  in  1  cpu access request; held with cpu_we/addr/wdata stable until cpu_gnt.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_WIDTH  cpu address.
- cpu_wdata  in  DATA_WIDTH  cpu write data.
- cpu_gnt  out  1  access accepted this cycle.
- cpu_rvalid  out  1  cpu read data valid.
- cpu_rdata  out  DATA_WIDTH  cpu read data.
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  same widths and rules as the cpu equivalents.
- dbg_gnt, dbg_rvalid, dbg_rdata  out  same widths and rules as the cpu equivalents.
- mem_en  out  1  memory enable (ena).
- mem_we  out  1  memory write enable (wea).
- mem_addr  out  ADDR_WIDTH  memory address (addra).
- mem_wdata  out  DATA_WIDTH  memory write data (dina).
- mem_rdata  in  DATA_WIDTH  memory read data (douta).

Behaviour:
- Reset (resetn=0, asynchronous):
  - state = CPU_PRIO; run counter = 0; tag pipeline cleared.
  - All gnt, rvalid, mem_en and mem_we outputs = 0.
  - rdata outputs = 0; mem_addr and mem_wdata = 0.
- Grant selection is combinational from req inputs and registered state. A grant happens in the same cycle the req is seen.
  - At most one of cpu_gnt and dbg_gnt is high in any cycle.
- mem_en = cpu_gnt | dbg_gnt. mem_we, mem_addr and mem_wdata are muxed from the granted port. When nothing is granted they are 0.
- State machine:
  - CPU_PRIO:
    - cpu_req wins if asserted; otherwise dbg_req wins.
    - On a cpu grant with dbg_req=1, the run counter increments.
    - When the counter would reach MAX_CPU_RUN, go to DBG_PRIO.
    - The counter clears on any dbg grant, or in any cycle where dbg_req=0.
  - DBG_PRIO:
    - dbg wins if dbg_req=1, and the block returns to CPU_PRIO with counter 0.
    - If dbg_req has dropped, cpu may be granted; return to CPU_PRIO with counter 0.
  - DBG_LOCK: only present with the optional feature.
- Read return:
  - Each granted read pushes an owner tag into a READ_LATENCY-deep shift register.
  - When the tag emerges, the owner's rvalid=1 for exactly one cycle. Its rdata is registered from mem_rdata in that cycle.
  - The other port's rvalid stays 0.
- Writes produce no rvalid.
- Back-to-back reads, one per cycle, return in issue order with no bubbles.
- Simultaneous cpu_req and dbg_req: resolved per state, and the loser keeps waiting.
- Neither requesting: idle cycle. The counter clears because dbg_req=0.
- Reset mid-operation drops all in-flight reads; no rvalid follows.
- rdata holds its last value when rvalid=0.

Optional Feature:
- Macro: MEM_ARB_LOCK_EN.
- With the macro defined:
  - Adds input port dbg_lock (1 bit) and state DBG_LOCK.
  - If dbg_lock=1 on a cycle dbg is granted, enter DBG_LOCK.
  - In DBG_LOCK, cpu_gnt is forced to 0 regardless of cpu_req, which stalls the CPU while loading.
  - Leave DBG_LOCK to CPU_PRIO (counter 0) on the first cycle dbg_lock=0.
  - Reads already in flight still complete normally.
- Without the macro: no dbg_lock port, no DBG_LOCK state, and behaviour is exactly as above.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding localparams ST_CPU_PRIO=2'd0, ST_DBG_PRIO=2'd1, ST_DBG_LOCK=2'd2;
  - owner tag encoding TAG_CPU=1'b0, TAG_DBG=1'b1;
  - default widths 16/8.
- One sub-module, mem_arb_rd_tracker: the READ_LATENCY-deep valid+tag shift register plus the rdata/rvalid steering registers.

Test Plan:
- Reset: hold resetn=0 with cpu_req=1 -> all gnt, rvalid, mem_en = 0. Release -> cpu_gnt=1 on the first cycle.
- CPU solo reads at 0xFFFC, 0xFFFD, with memory holding 0x00 and 0x80 -> cpu_rvalid on cycles N+1 and N+2, cpu_rdata 0x00 then 0x80, dbg_rvalid=0 throughout.
- Starvation: cpu_req and dbg_req held continuously -> grant pattern CCCC D CCCC D (MAX_CPU_RUN=4). No grant overlap.
- Dbg write then cpu read of the same address: dbg writes 0xA9 to 0x0200, then cpu reads 0x0200 -> cpu_rdata=0xA9.
- Reset mid-flight: assert resetn=0 one cycle after a granted cpu read -> no cpu_rvalid after release, state = CPU_PRIO.
- MEM_ARB_LOCK_EN: dbg_lock=1 with 10 dbg writes while cpu_req=1 -> cpu_gnt=0 for all 10 cycles. Drop dbg_lock -> cpu_gnt=1 on the next cycle.
